mem_fr_initiator: RTL and testbench

Front-door initiator for the 1Kb single-port memory. On a start pulse it writes a seed-derived pattern to every address, reads every address back, and compares each read against the expected value. It drives the memory's valid/ready request port and reports pass/fail, an error count and the first failing address. It sits between a test/boot controller and the memory, and acts as a power-on and on-demand front-door self-check.

---
 rtl/mem_fr_pkg.sv | 21 ++
 rtl/mem_fr_req_ctrl.sv | 91 +++++++++
 rtl/mem_fr_initiator.sv | 104 ++++++++++
 tb/tb_mem_fr_initiator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_fr_pkg.sv
// Shared types and constants for the memory front-door initiator.
// The pattern helper is width-generic: callers truncate to their data width.
package mem_fr_pkg;
  localparam int FR_WIDTH  = 16;
  localparam int FR_DEPTH  = 64;
  localparam int FR_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_REL,
    ST_RD_REQ,
    ST_RD_REL,
    ST_DONE
  } fr_state_e;

  function automatic logic [63:0] fr_pattern(input logic [63:0] seed,
                                             input logic [31:0] addr);
    return seed ^ {32'd0, addr};
  endfunction
endpackage

// File: rtl/mem_fr_req_ctrl.sv
// Handshake sequencer for the front-door initiator: REQ/REL phases per word.
// MEM_FR_INITIATOR_TIMEOUT_EN adds a per-state watchdog that forces DONE.
module mem_fr_req_ctrl
  import mem_fr_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_start,
  input  logic      i_ready,
  input  logic      i_last,
  output fr_state_e o_state,
  output logic      o_valid,
  output logic      o_wr,
  output logic      o_adv,
  output logic      o_sample,
  output logic      o_fin,
  output logic      o_timeout
);
  fr_state_e r_state, w_nxt;
  logic      w_hs_state;
  logic      w_to;

  assign w_hs_state = (r_state == ST_WR_REQ) || (r_state == ST_WR_REL) ||
                      (r_state == ST_RD_REQ) || (r_state == ST_RD_REL);

`ifdef MEM_FR_INITIATOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  assign w_to = w_hs_state && (r_cnt == CW'(TIMEOUT));

  // Counts cycles spent in the current handshake state; restarts on any move.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !w_hs_state || (w_nxt != r_state)) r_cnt <= '0;
    else                                               r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    o_valid  = 1'b0;
    o_wr     = 1'b0;
    o_adv    = 1'b0;
    o_sample = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_start) w_nxt = ST_WR_REQ;
      ST_WR_REQ: begin
        o_valid = 1'b1;
        o_wr    = 1'b1;
        if (i_ready) w_nxt = ST_WR_REL;
      end
      ST_WR_REL: if (!i_ready) begin
        o_adv = 1'b1;
        w_nxt = i_last ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_RD_REQ: begin
        o_valid = 1'b1;
        if (i_ready) begin
          o_sample = 1'b1;
          w_nxt    = ST_RD_REL;
        end
      end
      ST_RD_REL: if (!i_ready) begin
        o_adv = !i_last;
        w_nxt = i_last ? ST_DONE : ST_RD_REQ;
      end
      ST_DONE:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
    // Watchdog wins over the handshake: abandon the word and finish.
    if (w_to) begin
      w_nxt    = ST_DONE;
      o_valid  = 1'b0;
      o_adv    = 1'b0;
      o_sample = 1'b0;
    end
  end

  assign o_state   = r_state;
  assign o_fin     = (w_nxt == ST_DONE) && (r_state != ST_DONE);
  assign o_timeout = w_to;
endmodule

// File: rtl/mem_fr_initiator.sv
// Front-door memory self-check: write seed^addr everywhere, read back, compare.
// Optional handshake watchdog enabled by defining MEM_FR_INITIATOR_TIMEOUT_EN.
module mem_fr_initiator
  import mem_fr_pkg::*;
#(
  parameter int WIDTH      = FR_WIDTH,
  parameter int DEPTH      = FR_DEPTH,
  parameter int ADDR_WIDTH = FR_ADDR_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic                  w_r_data_o,
  output logic                  valid_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  ready_i
);
  fr_state_e             w_state;
  logic                  w_valid, w_wr, w_adv, w_sample, w_fin, w_to;
  logic                  w_last, w_accept;
  logic [WIDTH-1:0]      w_exp;
  logic [WIDTH-1:0]      r_seed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err;
  logic                  r_pass;

  mem_fr_req_ctrl #(.TIMEOUT(TIMEOUT)) u_req_ctrl (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_start   (start_i),
    .i_ready   (ready_i),
    .i_last    (w_last),
    .o_state   (w_state),
    .o_valid   (w_valid),
    .o_wr      (w_wr),
    .o_adv     (w_adv),
    .o_sample  (w_sample),
    .o_fin     (w_fin),
    .o_timeout (w_to)
  );

  assign w_last   = (r_addr == ADDR_WIDTH'(DEPTH - 1));
  assign w_accept = (w_state == ST_IDLE) && start_i;
  assign w_exp    = WIDTH'(fr_pattern(64'(r_seed), 32'(r_addr)));

  // Address wraps to 0 after the last write since DEPTH == 2**ADDR_WIDTH.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_seed      <= '0;
      r_addr      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_seed      <= seed_i;
        r_addr      <= '0;
        r_err_cnt   <= '0;
        r_first_err <= '0;
        r_pass      <= 1'b0;
      end
      if (w_adv) r_addr <= r_addr + 1'b1;
      if (w_sample && (rdata_i != w_exp)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt == '0) r_first_err <= r_addr;
      end
      if (w_fin) r_pass <= (r_err_cnt == '0) && !w_to;
    end
  end

`ifdef MEM_FR_INITIATOR_TIMEOUT_EN
  logic r_timeout;
  always_ff @(posedge clk_i) begin
    if (!rst_i)        r_timeout <= 1'b0;
    else if (w_accept) r_timeout <= 1'b0;
    else if (w_to)     r_timeout <= 1'b1;
  end
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign busy_o           = (w_state == ST_WR_REQ) || (w_state == ST_WR_REL) ||
                            (w_state == ST_RD_REQ) || (w_state == ST_RD_REL);
  assign done_o           = (w_state == ST_DONE);
  assign pass_o           = r_pass;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err;
  assign addr_o           = r_addr;
  assign wdata_o          = w_exp;
  assign w_r_data_o       = w_wr;
  assign valid_o          = w_valid;
endmodule

// File: tb/tb_mem_fr_initiator.sv
// Bench for mem_fr_initiator: registered memory model with read-side stuck bits,
// results predicted per run from seed and fault masks.
module tb_mem_fr_initiator;
  localparam int W  = 16;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [W-1:0]  seed_i = '0;
  logic          busy_o, done_o, pass_o, timeout_o, w_r_data_o, valid_o;
  logic [AW:0]   err_cnt_o;
  logic [AW-1:0] first_err_addr_o, addr_o;
  logic [W-1:0]  wdata_o;
  logic          m_ready;
  logic [W-1:0]  m_rdata = '0;

  logic [W-1:0]  mem  [D];
  logic [W-1:0]  mask [D];
  logic          hang = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  always #5 clk = ~clk;

  mem_fr_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .w_r_data_o(w_r_data_o),
    .valid_o(valid_o), .rdata_i(m_rdata), .ready_i(m_ready)
  );

  // Registered memory: acks one cycle after valid, holds ready while valid stays up.
  always_ff @(posedge clk) begin
    if (!rst_i || hang) m_ready <= 1'b0;
    else if (valid_o && !m_ready) begin
      m_ready <= 1'b1;
      if (w_r_data_o) mem[addr_o] <= wdata_o;
      else            m_rdata     <= mem[addr_o] & ~mask[addr_o];
    end else if (!valid_o) m_ready <= 1'b0;
  end

  logic          p_valid = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [W-1:0]  p_wdata = '0;
  always @(negedge clk) begin
    if (rst_i) begin
      if (valid_o && !p_valid && m_ready) viol++;
      if (valid_o && p_valid &&
          (addr_o != p_addr || wdata_o != p_wdata || w_r_data_o != p_wr)) viol++;
    end
    p_valid = rst_i ? valid_o : 1'b0;
    p_addr  = addr_o;
    p_wdata = wdata_o;
    p_wr    = w_r_data_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected result: a word fails when a stuck-at-0 bit hits a 1 in its pattern.
  task automatic model(input logic [W-1:0] seed, output int errs, output int first);
    logic [W-1:0] pat;
    errs  = 0;
    first = 0;
    for (int a = 0; a < D; a++) begin
      pat = seed ^ W'(a);
      if ((pat & mask[a]) != '0) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
  endtask

  task automatic clear_mask();
    for (int a = 0; a < D; a++) mask[a] = '0;
  endtask

  task automatic run(input logic [W-1:0] seed, input int inj, input string tag);
    int busy, errs, first, bad;
    bit got_done;
    logic [W-1:0] pat;
    model(seed, errs, first);
    @(negedge clk);
    seed_i  = seed;
    start_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    seed_i   = W'($urandom);
    busy     = 0;
    got_done = 0;
    for (int c = 0; c < 1000 && !got_done; c++) begin
      if (done_o) got_done = 1;
      else begin
        if (busy_o) busy++;
        start_i = (c == inj);
        @(negedge clk);
      end
    end
    start_i = 1'b0;
    chk({tag, " done"},  32'(got_done), 1);
    chk({tag, " busy"},  32'(busy), 8 * D);
    chk({tag, " err"},   32'(err_cnt_o), 32'(errs));
    chk({tag, " first"}, 32'(first_err_addr_o), 32'(first));
    chk({tag, " pass"},  32'(pass_o), 32'(errs == 0));
    chk({tag, " tmo"},   32'(timeout_o), 0);
    bad = 0;
    for (int a = 0; a < D; a++) begin
      pat = seed ^ W'(a);
      if (mem[a] !== pat) bad++;
    end
    chk({tag, " memwr"}, 32'(bad), 0);
    @(negedge clk);
    chk({tag, " donepulse"}, 32'(done_o), 0);
    chk({tag, " hold"},      32'(pass_o), 32'(errs == 0));
    chk({tag, " idle"},      32'(busy_o), 0);
  endtask

  initial begin
    int nf;
    clear_mask();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst valid", 32'(valid_o), 0);
    chk("rst wr",    32'(w_r_data_o), 0);
    chk("rst busy",  32'(busy_o), 0);
    chk("rst done",  32'(done_o), 0);
    chk("rst pass",  32'(pass_o), 0);
    chk("rst tmo",   32'(timeout_o), 0);
    chk("rst addr",  32'(addr_o), 0);
    chk("rst wdata", 32'(wdata_o), 0);
    chk("rst err",   32'(err_cnt_o), 0);
    chk("rst first", 32'(first_err_addr_o), 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);

    run(16'hA5A5, 200, "clean");
    chk("clean mem5", 32'(mem[5]), 32'h0000A5A0);

    mask[9]  = 16'h0008;
    mask[40] = 16'h0008;
    run(16'h0000, -1, "stuck");
    clear_mask();

    for (int r = 0; r < 4; r++) begin
      nf = $urandom_range(0, 4);
      for (int k = 0; k < nf; k++)
        mask[$urandom_range(0, D - 1)] |= W'(1) << $urandom_range(0, W - 1);
      run(W'($urandom), $urandom_range(5, 500), $sformatf("rand%0d", r));
      clear_mask();
    end

    // Reset in the middle of a run, then a fresh run must complete.
    @(negedge clk);
    seed_i  = 16'h1234;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (99) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst valid", 32'(valid_o), 0);
    chk("midrst busy",  32'(busy_o), 0);
    chk("midrst err",   32'(err_cnt_o), 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    run(16'h5A3C, -1, "afterrst");

`ifdef MEM_FR_INITIATOR_TIMEOUT_EN
    begin
      int busy;
      bit got_done;
      hang = 1'b1;
      @(negedge clk);
      seed_i  = 16'hBEEF;
      start_i = 1'b1;
      @(negedge clk);
      start_i  = 1'b0;
      busy     = 0;
      got_done = 0;
      for (int c = 0; c < 200 && !got_done; c++) begin
        if (done_o) got_done = 1;
        else begin
          if (busy_o) busy++;
          @(negedge clk);
        end
      end
      chk("tmo done",  32'(got_done), 1);
      chk("tmo busy",  32'(busy), TO + 1);
      chk("tmo flag",  32'(timeout_o), 1);
      chk("tmo pass",  32'(pass_o), 0);
      chk("tmo valid", 32'(valid_o), 0);
      hang = 1'b0;
      repeat (2) @(negedge clk);
      run(16'h0F0F, -1, "aftertmo");
    end
`endif

    chk("protocol", 32'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
